dmem_responder: RTL

Memory-side responder for the core's data-memory port. It accepts one load or store request at a time over a valid/ready request channel. After a fixed, configurable latency it performs the access on an internal word array and returns a response over a valid/ready response channel. It sits between the CPU's load/store path and the data storage, and replaces the single-cycle data memory once the core moves to a handshaked memory interface.

---
 rtl/dmem_responder.sv | 99 +++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Handshaked data-memory responder: one request at a time, fixed LATENCY, then a held response.
// Define DMEM_RESP_MISALIGN_ERR_EN to flag req_addr[1:0]!=0 as an error instead of forcing alignment.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_we,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic          we_q;
    logic [3:0]    be_q;
    logic [31:0]   mem [DEPTH_WORDS];

    logic [AW-1:0] idx;
    logic          oor;
    logic          bad;
    logic          fire;

    assign idx = addr_q[AW+1:2];
    assign oor = |addr_q[31:AW+2];
`ifdef DMEM_RESP_MISALIGN_ERR_EN
    assign bad = oor | (|addr_q[1:0]);
`else
    logic unused_lsbs;
    assign unused_lsbs = ^addr_q[1:0];
    assign bad = oor;
`endif

    // the access happens exactly once, on the WAIT->RESP edge
    assign fire      = (state == S_WAIT) && (cnt == '0);
    assign req_ready = (state == S_IDLE);
    assign rsp_valid = (state == S_RESP);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            be_q      <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (req_valid) begin
                    addr_q  <= req_addr;
                    wdata_q <= req_wdata;
                    we_q    <= req_we;
                    be_q    <= req_be;
                    cnt     <= CW'(LATENCY - 1);
                    state   <= S_WAIT;
                end
                S_WAIT: if (fire) begin
                    rsp_rdata <= (!we_q && !bad) ? mem[idx] : '0;
                    rsp_err   <= bad;
                    state     <= S_RESP;
                end else begin
                    cnt <= cnt - 1'b1;
                end
                S_RESP: if (rsp_ready) begin
                    rsp_rdata <= '0;
                    rsp_err   <= 1'b0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // storage is deliberately not reset; reset only blocks the write by leaving WAIT
    always_ff @(posedge clk) begin
        if (fire && we_q && !bad) begin
            for (int i = 0; i < 4; i++)
                if (be_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
        end
    end
endmodule
